// File: rtl/maze_arb_pkg.sv
// maze_arb_pkg: shared types and constants for the MAZE arbiter request agents.
//   - pkt_t          : FIFO entry {qos, data} at the default payload width
//   - head_state_e   : head-of-queue state machine encoding
//   - age_w / cnt_w  : width helpers for the aging counter and FIFO occupancy
//   - DEFAULT_*      : default parameter values for the requester
package maze_arb_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_AGE_MAX = 15;

    typedef struct packed {
        logic                      qos;
        logic [DEFAULT_DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_WAIT     = 2'd1,
        HS_PROMOTED = 2'd2
    } head_state_e;

    // An AGE_MAX of 0 still needs a 1-bit counter so the declaration stays legal.
    function automatic int age_w(input int age_max);
        return (age_max < 1) ? 1 : $clog2(age_max + 1);
    endfunction

    // Occupancy spans 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: handshake bundle between one arbiter input agent and its
// surroundings (upstream producer, arbiter, downstream consumer).
//   slave  modport : the requester itself
//   master modport : the environment driving it
//   in_valid/in_ready/in_data/in_qos : upstream packet push
//   req/qos/gnt                      : arbiter request, QoS and grant
//   out_valid/out_data               : packet handed downstream on grant
//   promoted                         : head packet currently aged-promoted
interface arb_requester_if
    import maze_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_qos;
    logic              req;
    logic              qos;
    logic              gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              promoted;

    modport slave (
        input  in_valid, in_data, in_qos, gnt,
        output in_ready, req, qos, out_valid, out_data, promoted
    );

    modport master (
        output in_valid, in_data, in_qos, gnt,
        input  in_ready, req, qos, out_valid, out_data, promoted
    );

endinterface

// File: rtl/arb_requester_sync_fifo.sv
// sync_fifo: generic single-clock FIFO, DEPTH x WIDTH, DEPTH a power of two.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_wdata at the tail (ignored when full)
//   i_pop     : retire the head (ignored when empty)
//   o_rdata   : current head entry (meaningful only when not empty)
//   o_full, o_empty, o_count : occupancy status from the registered count
module sync_fifo
    import maze_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_W + 1,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/arb_requester.sv
// arb_requester: per-input request agent for the MAZE QoS arbiter. Buffers
// packets, requests the arbiter with the head packet, dequeues on grant and
// ages a denied head so it is promoted to high QoS after AGE_MAX cycles.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : arb_requester_if.slave (push, req/qos/gnt, out, promoted)
//
// Head FSM:
//   state       | meaning
//   HS_IDLE     | FIFO empty, no request
//   HS_WAIT     | head requesting, not yet aged out
//   HS_PROMOTED | head denied for AGE_MAX cycles, forced to high QoS
module arb_requester
    import maze_arb_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AGE_MAX = DEFAULT_AGE_MAX
) (
    input logic            clk,
    input logic            rst,
    arb_requester_if.slave bus
);

    localparam int   AGE_W    = age_w(AGE_MAX);
    localparam int   CNT_W    = cnt_w(DEPTH);
    localparam logic AGING_EN = (AGE_MAX != 0);
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    typedef struct packed {
        logic              qos;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           w_wdata;
    entry_t           w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_req;
    logic             w_still_busy;
    logic             w_promoted;
    logic [AGE_W-1:0] w_wait_nxt;
    logic [AGE_W-1:0] r_wait_cnt;
    head_state_e      r_state;
    head_state_e      w_state_nxt;

    assign w_wdata = '{qos: bus.in_qos, data: bus.in_data};
    assign w_push  = bus.in_valid & ~w_full;
    assign w_req   = ~w_empty;
    assign w_pop   = w_req & bus.gnt;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A pop leaves the queue non-empty unless it took the last entry with no
    // concurrent push (a push while full is blocked, but then DEPTH >= 2 remain).
    assign w_still_busy = (w_count != CNT_W'(1)) | w_push;

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (w_pop) begin
            w_wait_nxt = '0;
        end else if (w_req && !bus.gnt && (r_wait_cnt != AGE_LIM)) begin
            w_wait_nxt = r_wait_cnt + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PROMOTED tracks (req && wait_cnt == AGE_MAX) one-for-one, so the flag can
    // come straight from the state register.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HS_IDLE: begin
                if (w_push) w_state_nxt = HS_WAIT;
            end
            HS_WAIT, HS_PROMOTED: begin
                if (w_pop) begin
                    w_state_nxt = w_still_busy ? HS_WAIT : HS_IDLE;
                end else if (AGING_EN && (w_wait_nxt == AGE_LIM)) begin
                    w_state_nxt = HS_PROMOTED;
                end
            end
            default: w_state_nxt = HS_IDLE;
        endcase
    end

    assign w_promoted    = (r_state == HS_PROMOTED);
    assign bus.in_ready  = ~w_full;
    assign bus.req       = w_req;
    assign bus.qos       = w_req & (w_head.qos | w_promoted);
    assign bus.out_valid = w_pop;
    assign bus.out_data  = w_pop ? w_head.data : '0;
    assign bus.promoted  = w_promoted;

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
    import maze_arb_pkg::*;

    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int AGE_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arb_requester_if #(.DATA_W(DW)) bus ();

    arb_requester #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .AGE_MAX (AGE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a packet queue plus the number of denied cycles the
    // current head has spent at the front.
    logic [DW:0] mq [$];
    int          age;

    function automatic bit m_req();
        return mq.size() != 0;
    endfunction

    function automatic bit m_prom();
        return m_req() && (AGE_MAX != 0) && (age >= AGE_MAX);
    endfunction

    function automatic bit m_qos();
        if (!m_req()) return 1'b0;
        return mq[0][DW] || m_prom();
    endfunction

    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit m_oval();
        return m_req() && bus.gnt;
    endfunction

    function automatic logic [DW-1:0] m_odata();
        if (!m_oval()) return '0;
        return mq[0][DW-1:0];
    endfunction

    task automatic m_clear();
        mq.delete();
        age = 0;
    endtask

    // Called at posedge+1; leaves the bench at posedge+5 ready to sample.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit q, input bit g);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_qos   = q;
        bus.gnt      = g;
        #4;
    endtask

    // Clocks one edge and applies the same edge to the model.
    task automatic advance();
        bit          pop;
        bit          push;
        logic [DW:0] ent;
        pop  = m_oval();
        push = bus.in_valid && m_ready();
        ent  = {bus.in_qos, bus.in_data};
        @(posedge clk);
        if (pop) begin
            mq.delete(0);
            age = 0;
        end else if (m_req()) begin
            age++;
        end
        if (push) mq.push_back(ent);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_qos   = 1'b0;
        bus.gnt      = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.req); end
        n_checks++; if (bus.qos !== 1'b0) begin n_fail++; $display("FAIL reset_qos: got %b expected 0", bus.qos); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        n_checks++; if (bus.promoted !== 1'b0) begin n_fail++; $display("FAIL reset_promoted: got %b expected 0", bus.promoted); end
        advance();
    endtask

    task automatic test_passthrough();
        for (int k = 0; k < 2; k++) begin
            bit qv;
            qv = (k == 1);
            drive(1, 32'hA5A5_0001, qv, 1);
            n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL pass_req_before: got %b expected 0", bus.req); end
            advance();
            drive(0, '0, 0, 1);
            n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL pass_req: got %b expected 1", bus.req); end
            n_checks++; if (bus.qos !== qv) begin n_fail++; $display("FAIL pass_qos: got %b expected %b", bus.qos, qv); end
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_out_valid: got %b expected 1", bus.out_valid); end
            n_checks++; if (bus.out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL pass_out_data: got %h expected a5a50001", bus.out_data); end
            advance();
            drive(0, '0, 0, 0);
            n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL pass_empty_after: got req %b expected 0", bus.req); end
            advance();
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(32'h100 + i), 0, 0);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b expected 1", i, bus.in_ready); end
            advance();
        end
        drive(1, 32'hDEAD_BEEF, 0, 0);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got in_ready %b expected 0", bus.in_ready); end
        advance();
        drive(0, '0, 0, 1);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_in_pop: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.out_data !== 32'h100) begin n_fail++; $display("FAIL fill_first_out: got %h expected 100", bus.out_data); end
        advance();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after_pop: got %b expected 1", bus.in_ready); end
        advance();
        for (int i = 1; i < 4; i++) begin
            drive(0, '0, 0, 1);
            n_checks++; if (bus.out_data !== 32'(32'h100 + i)) begin n_fail++; $display("FAIL fill_order_%0d: got %h expected %h", i, bus.out_data, 32'h100 + i); end
            advance();
        end
        drive(0, '0, 0, 1);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_fifth_dropped: got out_valid %b data %h expected 0", bus.out_valid, bus.out_data); end
        advance();
    endtask

    task automatic test_aging();
        drive(1, 32'h55, 0, 0);
        advance();
        for (int k = 1; k <= 20; k++) begin
            bit ex;
            ex = (k >= AGE_MAX + 1);
            drive(k == 1, 32'h66, 0, 0);
            n_checks++; if (bus.qos !== ex) begin n_fail++; $display("FAIL age_qos_c%0d: got %b expected %b", k, bus.qos, ex); end
            n_checks++; if (bus.promoted !== ex) begin n_fail++; $display("FAIL age_prom_c%0d: got %b expected %b", k, bus.promoted, ex); end
            advance();
        end
        drive(0, '0, 0, 1);
        n_checks++; if (bus.out_data !== 32'h55) begin n_fail++; $display("FAIL age_grant_data: got %h expected 55", bus.out_data); end
        n_checks++; if (bus.qos !== 1'b1) begin n_fail++; $display("FAIL age_grant_qos: got %b expected 1", bus.qos); end
        advance();
        for (int k = 1; k <= AGE_MAX + 1; k++) begin
            bit ex;
            ex = (k >= AGE_MAX + 1);
            drive(0, '0, 0, 0);
            n_checks++; if (bus.qos !== ex) begin n_fail++; $display("FAIL age2_qos_c%0d: got %b expected %b", k, bus.qos, ex); end
            n_checks++; if (bus.promoted !== ex) begin n_fail++; $display("FAIL age2_prom_c%0d: got %b expected %b", k, bus.promoted, ex); end
            advance();
        end
        drive(0, '0, 0, 1);
        n_checks++; if (bus.out_data !== 32'h66) begin n_fail++; $display("FAIL age2_grant_data: got %h expected 66", bus.out_data); end
        advance();
    endtask

    task automatic test_simul();
        drive(1, 32'h200, 0, 0); advance();
        drive(1, 32'h201, 0, 0); advance();
        for (int k = 0; k < 10; k++) begin
            logic [DW-1:0] ex;
            ex = (k < 2) ? 32'(32'h200 + k) : 32'(32'h300 + k - 2);
            drive(1, 32'(32'h300 + k), 0, 1);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid_%0d: got %b expected 1", k, bus.out_valid); end
            n_checks++; if (bus.out_data !== ex) begin n_fail++; $display("FAIL simul_data_%0d: got %h expected %h", k, bus.out_data, ex); end
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready_%0d: got %b expected 1", k, bus.in_ready); end
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, '0, 0, 1);
            n_checks++; if (bus.out_data !== 32'(32'h308 + k)) begin n_fail++; $display("FAIL simul_drain_%0d: got %h expected %h", k, bus.out_data, 32'h308 + k); end
            advance();
        end
        drive(0, '0, 0, 0);
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got req %b expected 0", bus.req); end
        advance();
    endtask

    task automatic test_spurious_and_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, 0, 1);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL spurious_valid_%0d: got %b expected 0", k, bus.out_valid); end
            n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL spurious_req_%0d: got %b expected 0", k, bus.req); end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(32'h400 + i), 1'b1, 0);
            advance();
        end
        drive(0, '0, 0, 0);
        n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_req: got %b expected 1", bus.req); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b expected 0", bus.req); end
        n_checks++; if (bus.qos !== 1'b0) begin n_fail++; $display("FAIL midrst_qos: got %b expected 0", bus.qos); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        drive(0, '0, 0, 1);
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL postrst_req: got %b expected 0", bus.req); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_valid: got %b expected 0", bus.out_valid); end
        advance();
        drive(1, 32'h500, 0, 0);
        advance();
        drive(0, '0, 0, 1);
        n_checks++; if (bus.out_data !== 32'h500) begin n_fail++; $display("FAIL postrst_data: got %h expected 500", bus.out_data); end
        n_checks++; if (bus.qos !== 1'b0) begin n_fail++; $display("FAIL postrst_qos: got %b expected 0", bus.qos); end
        advance();
        drive(0, '0, 0, 0);
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL postrst_empty: got req %b expected 0", bus.req); end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit v;
            bit g;
            v = ($urandom_range(0, 3) != 0);
            // Alternate grant-starved and grant-rich phases so aging is exercised.
            if ((c % 100) < 40) g = ($urandom_range(0, 19) == 0);
            else                g = ($urandom_range(0, 9) < 5);
            drive(v, $urandom, 1'($urandom_range(0, 1)), g);
            n_checks++; if (bus.req !== m_req()) begin n_fail++; $display("FAIL rnd_req_c%0d: got %b expected %b", c, bus.req, m_req()); end
            n_checks++; if (bus.qos !== m_qos()) begin n_fail++; $display("FAIL rnd_qos_c%0d: got %b expected %b", c, bus.qos, m_qos()); end
            n_checks++; if (bus.promoted !== m_prom()) begin n_fail++; $display("FAIL rnd_prom_c%0d: got %b expected %b", c, bus.promoted, m_prom()); end
            n_checks++; if (bus.in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready_c%0d: got %b expected %b", c, bus.in_ready, m_ready()); end
            n_checks++; if (bus.out_valid !== m_oval()) begin n_fail++; $display("FAIL rnd_valid_c%0d: got %b expected %b", c, bus.out_valid, m_oval()); end
            n_checks++; if (bus.out_data !== m_odata()) begin n_fail++; $display("FAIL rnd_data_c%0d: got %h expected %h", c, bus.out_data, m_odata()); end
            advance();
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_passthrough();
        test_fill();
        test_aging();
        test_simul();
        test_spurious_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
# arb_requester

Per-input request agent for the MAZE QoS arbiter. It buffers incoming packets in a small FIFO, presents the head packet's `req`/`qos` bit to the arbiter, and dequeues on `gnt`. The arbiter serves fixed lowest-index priority, so this block ages a waiting head packet and promotes it to high QoS to bound starvation. One instance sits on each arbiter input, and the `WIDTH` instances' `req`/`qos` bits are concatenated into the arbiter vectors.

## Interface
- `DATA_W`, 32: packet payload width.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `AGE_MAX`, 15: wait cycles before promotion; 0 disables aging.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: upstream packet valid.
- `in_ready` output 1: FIFO can accept a packet.
- `in_data` input DATA_W: packet payload.
- `in_qos` input 1: packet native QoS (1 = high).
- `req` output 1: request bit to the arbiter.
- `qos` output 1: QoS bit to the arbiter.
- `gnt` input 1: grant bit from the arbiter (combinational, same cycle as `req`).
- `out_valid` output 1: packet handed downstream this cycle (`req & gnt`).
- `out_data` output DATA_W: head payload; valid only when `out_valid`.
- `promoted` output 1: head is currently aged-promoted (debug/perf).

## Operation
- Push: when `in_valid & in_ready`, write {`in_qos`, `in_data`} at the tail.
- Pop: when `req & gnt`, retire the head and pulse `out_valid`. Any `gnt` while `req`=0 is ignored; there is no state change.
- `in_ready = !full`. It does not depend on `gnt`, so there is no combinational path from `gnt` to `in_ready`.
- Simultaneous push and pop with the FIFO not full: count is unchanged and both pointers advance.
- `req = !empty`, driven from registered count only.
- `qos = req & (head_qos | promoted)`. `qos` is never 1 while `req`=0.
- Aging counter `wait_cnt` (width $clog2(AGE_MAX+1)):
  - Increments each cycle `req & !gnt`.
  - Saturates at AGE_MAX.
  - Clears to 0 on pop, so every new head starts at 0.
- `promoted = (AGE_MAX != 0) & req & (wait_cnt == AGE_MAX)`.
- Head state machine:
  - IDLE (empty) → WAIT on push.
  - WAIT → PROMOTED when `wait_cnt` reaches AGE_MAX without a grant.
  - WAIT or PROMOTED → WAIT on pop if the FIFO is still non-empty; otherwise → IDLE.
  - A native-high-QoS head in WAIT already drives `qos`=1, and still ages. The `promoted` flag is independent of `head_qos`.

## Timing
- Reset values: `req`=0, `qos`=0, `in_ready`=1, `out_valid`=0, `out_data`=0, `promoted`=0. Pointers, count and `wait_cnt` reset to 0.
- Push into empty FIFO: `req`=1 in the cycle after the push edge (1-cycle latency).
- Grant: `out_valid`/`out_data` are combinational in the grant cycle. The next head's `req` is visible the following cycle (back-to-back pops possible every cycle).
- Promotion: with AGE_MAX=N and continuous denial, `qos` rises N cycles after `req` first rises.
- Full: `in_ready`=0 when count==DEPTH. A pop in that cycle frees a slot, and `in_ready` returns next cycle.
- Pointer wrap is modulo DEPTH. Count ranges 0..DEPTH, with a width of $clog2(DEPTH)+1.
- Reset asserted mid-operation: all entries discarded and outputs return to reset values immediately (async). There is no partial-packet recovery.

## Structure
- Shared package `maze_arb_pkg`:
  - Packet entry typedef {qos, data}.
  - AGE/DEPTH width helper constants.
  - Default AGE_MAX.
- Sub-module `sync_fifo`: a generic DEPTH×(DATA_W+1) FIFO with push/pop/full/empty/count. `arb_requester` wraps it with the aging counter and head FSM.

## Test plan
- Reset then idle: the bench must check the reset values above.
  - Hold `rst`=1 for 3 cycles, release with no input → `req`=0, `qos`=0, `in_ready`=1.
- Native-QoS pass-through:
  - Push payload 0xA5A5_0001 with `in_qos`=0, hold `gnt`=1 → `req`=1 next cycle, `qos`=0, `out_valid`=1 with `out_data`=0xA5A5_0001 in that cycle, FIFO empty after.
  - Repeat with `in_qos`=1 → `qos`=1 in the request cycle.
- Fill and back-pressure (DEPTH=4):
  - Push 4 packets with `gnt`=0 → `in_ready`=0 after the 4th, and a 5th `in_valid` is not accepted.
  - Grant once → `in_ready`=1 next cycle, and the packets come out in FIFO order.
- Aging (AGE_MAX=15):
  - Push 1 low-QoS packet, hold `gnt`=0 → `qos`=0 for cycles 1–15 of `req`, `qos`=`promoted`=1 from cycle 16.
  - Grant → the next head starts with `qos`=0 and `wait_cnt`=0.
- Simultaneous push/pop: with 2 entries, `in_valid`=1 and `gnt`=1 every cycle for 10 cycles → count stays 2, 10 packets out in order, no loss or duplicate.
- Spurious grant and mid-op reset:
  - `gnt`=1 while empty → no `out_valid`, no state change.
  - Assert `rst` asynchronously with 3 entries queued → `req`=0 immediately, FIFO empty after release.
